// File: rtl/sram128x8_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram128x8_ctrl_pkg
// Description : Shared constants and types for the 128x8 SRAM macro controller.
//               AW/DW give the macro geometry. RSP_DEPTH is the read-response
//               FIFO depth, which also sets the read credit limit.
// Revision    : 1.0 - initial release
// ============================================================================
package sram128x8_ctrl_pkg;

    localparam int AW        = 7;
    localparam int DW        = 8;
    localparam int DEPTH     = 128;
    localparam int RSP_DEPTH = 4;
    // Width of a counter that can hold 0..RSP_DEPTH inclusive
    localparam int CNT_W     = $clog2(RSP_DEPTH + 1);

    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] wmask;
    } req_t;

endpackage : sram128x8_ctrl_pkg
`default_nettype wire

// File: rtl/sram128x8_ctrl_rspfifo.sv
`default_nettype none
// ============================================================================
// Module      : sram128x8_ctrl_rspfifo
// Description : RSP_DEPTH-entry synchronous read-response FIFO with an
//               occupancy count. The read data is forced to zero while the
//               FIFO is empty.
// Ports       : i_clk    - clock
//               i_rstn   - synchronous active-low reset (flushes the FIFO)
//               i_push   - write i_wdata (ignored when full and not popping)
//               i_wdata  - data to write
//               i_pop    - remove the head entry (ignored when empty)
//               o_valid  - FIFO is not empty
//               o_rdata  - head entry
//               o_count  - number of stored entries, 0..RSP_DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module sram128x8_ctrl_rspfifo
    import sram128x8_ctrl_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_push,
    input  logic [DW-1:0]    i_wdata,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [DW-1:0]    o_rdata,
    output logic [CNT_W-1:0] o_count
);

    localparam int PW = $clog2(RSP_DEPTH);

    logic [DW-1:0]    r_mem_q [RSP_DEPTH];
    logic [PW-1:0]    r_wptr_q,  w_wptr_d;
    logic [PW-1:0]    r_rptr_q,  w_rptr_d;
    logic [CNT_W-1:0] r_count_q, w_count_d;
    logic             w_do_push;
    logic             w_do_pop;

    always_comb begin
        w_do_pop  = i_pop && (r_count_q != '0);
        // A simultaneous pop frees the slot, so a full FIFO can still accept
        w_do_push = i_push && ((r_count_q != CNT_W'(RSP_DEPTH)) || w_do_pop);
        w_wptr_d  = w_do_push ? r_wptr_q + PW'(1) : r_wptr_q;
        w_rptr_d  = w_do_pop  ? r_rptr_q + PW'(1) : r_rptr_q;
        w_count_d = r_count_q;
        if (w_do_push && !w_do_pop) begin
            w_count_d = r_count_q + CNT_W'(1);
        end else if (!w_do_push && w_do_pop) begin
            w_count_d = r_count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_wptr_q  <= '0;
            r_rptr_q  <= '0;
            r_count_q <= '0;
        end else begin
            r_wptr_q  <= w_wptr_d;
            r_rptr_q  <= w_rptr_d;
            r_count_q <= w_count_d;
        end
    end

    // Storage needs no reset: the empty-gating below hides stale entries
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem_q[r_wptr_q] <= i_wdata;
        end
    end

    assign o_valid = (r_count_q != '0);
    assign o_rdata = o_valid ? r_mem_q[r_rptr_q] : '0;
    assign o_count = r_count_q;

endmodule : sram128x8_ctrl_rspfifo
`default_nettype wire

// File: rtl/sram128x8_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sram128x8_ctrl
// Description : Host-side controller for a 128x8 SRAM macro. It converts
//               valid/ready request and response channels into the macro's
//               active-low CEN/GWEN/WEN pin protocol. After reset it can
//               optionally sweep-write INIT_VALUE into every word.
// Ports       : CLK, RSTN            - clock, synchronous active-low reset
//               req_valid/req_ready  - request handshake
//               req_we/addr/wdata/wmask - request payload (wmask active-high)
//               rsp_valid/rsp_ready  - read-response handshake
//               rsp_rdata            - read data
//               init_done            - sweep complete, requests accepted
//               sram_cen/gwen/wen/a/d - registered macro drives
//               sram_q               - macro read data
// Revision    : 1.0 - initial release
// ============================================================================
module sram128x8_ctrl
    import sram128x8_ctrl_pkg::*;
#(
    parameter bit          INIT_CLEAR = 1'b1,
    parameter logic [7:0]  INIT_VALUE = 8'h00
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    input  logic [DW-1:0] req_wmask,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          init_done,
    output logic          sram_cen,
    output logic          sram_gwen,
    output logic [DW-1:0] sram_wen,
    output logic [AW-1:0] sram_a,
    output logic [DW-1:0] sram_d,
    input  logic [DW-1:0] sram_q
);

    localparam state_e        c_RST_STATE = INIT_CLEAR ? S_INIT : S_RUN;
    localparam logic [AW-1:0] c_LAST_ADDR = AW'(DEPTH - 1);

    state_e           r_state_q,     w_state_d;
    logic [AW-1:0]    r_init_cnt_q,  w_init_cnt_d;
    logic             r_init_done_q, w_init_done_d;
    // Read in flight: stage A = pins hold a read, stage B = macro Q valid
    logic             r_a_rd_q,      w_a_rd_d;
    logic             r_b_rd_q,      w_b_rd_d;
    logic             r_cen_q,       w_cen_d;
    logic             r_gwen_q,      w_gwen_d;
    logic [DW-1:0]    r_wen_q,       w_wen_d;
    logic [AW-1:0]    r_a_q,         w_a_d;
    logic [DW-1:0]    r_d_q,         w_d_d;

    req_t             w_req;
    logic             w_accept;
    logic [CNT_W-1:0] w_fifo_count;
    logic [CNT_W:0]   w_credit_used;

    assign w_req = '{we: req_we, addr: req_addr, wdata: req_wdata, wmask: req_wmask};

    // Every read already reserved a FIFO slot when accepted, so the credit
    // check covers stored responses plus reads still in the pipe. It depends
    // only on registers, never on rsp_ready.
    assign w_credit_used = {1'b0, w_fifo_count}
                         + {{CNT_W{1'b0}}, r_a_rd_q}
                         + {{CNT_W{1'b0}}, r_b_rd_q};
    assign req_ready = (r_state_q == S_RUN) && r_init_done_q
                     && (w_credit_used < (CNT_W + 1)'(RSP_DEPTH));
    assign w_accept  = req_valid && req_ready;

    always_comb begin
        w_state_d     = r_state_q;
        w_init_cnt_d  = r_init_cnt_q;
        w_init_done_d = r_init_done_q;
        w_a_rd_d      = 1'b0;
        w_b_rd_d      = r_a_rd_q;
        // Idle pins by default; address and data hold their last value
        w_cen_d       = 1'b1;
        w_gwen_d      = 1'b1;
        w_wen_d       = '1;
        w_a_d         = r_a_q;
        w_d_d         = r_d_q;
        case (r_state_q)
            S_INIT: begin
                w_cen_d      = 1'b0;
                w_gwen_d     = 1'b0;
                w_wen_d      = '0;
                w_a_d        = r_init_cnt_q;
                w_d_d        = INIT_VALUE;
                w_init_cnt_d = r_init_cnt_q + AW'(1);
                if (r_init_cnt_q == c_LAST_ADDR) begin
                    w_state_d     = S_RUN;
                    w_init_done_d = 1'b1;
                end
            end
            S_RUN: begin
                w_init_done_d = 1'b1;
                if (w_accept) begin
                    w_cen_d = 1'b0;
                    w_a_d   = w_req.addr;
                    if (w_req.we) begin
                        w_gwen_d = 1'b0;
                        w_wen_d  = ~w_req.wmask;
                        w_d_d    = w_req.wdata;
                    end else begin
                        w_a_rd_d = 1'b1;
                    end
                end
            end
            default: begin
                w_state_d = S_RUN;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_state_q     <= c_RST_STATE;
            r_init_cnt_q  <= '0;
            r_init_done_q <= 1'b0;
            r_a_rd_q      <= 1'b0;
            r_b_rd_q      <= 1'b0;
            r_cen_q       <= 1'b1;
            r_gwen_q      <= 1'b1;
            r_wen_q       <= '1;
            r_a_q         <= '0;
            r_d_q         <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_init_cnt_q  <= w_init_cnt_d;
            r_init_done_q <= w_init_done_d;
            r_a_rd_q      <= w_a_rd_d;
            r_b_rd_q      <= w_b_rd_d;
            r_cen_q       <= w_cen_d;
            r_gwen_q      <= w_gwen_d;
            r_wen_q       <= w_wen_d;
            r_a_q         <= w_a_d;
            r_d_q         <= w_d_d;
        end
    end

    // Stage B means the macro sampled a read on the last edge, so Q is
    // valid now and is captured on this edge.
    sram128x8_ctrl_rspfifo u_rspfifo (
        .i_clk   (CLK),
        .i_rstn  (RSTN),
        .i_push  (r_b_rd_q),
        .i_wdata (sram_q),
        .i_pop   (rsp_valid && rsp_ready),
        .o_valid (rsp_valid),
        .o_rdata (rsp_rdata),
        .o_count (w_fifo_count)
    );

    assign init_done = r_init_done_q;
    assign sram_cen  = r_cen_q;
    assign sram_gwen = r_gwen_q;
    assign sram_wen  = r_wen_q;
    assign sram_a    = r_a_q;
    assign sram_d    = r_d_q;

endmodule : sram128x8_ctrl
`default_nettype wire

// File: tb/tb_sram128x8_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram128x8_ctrl
// Description : Self-checking bench for sram128x8_ctrl with a behavioural
//               macro model, a response scoreboard and a request vector table.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram128x8_ctrl;
    import sram128x8_ctrl_pkg::*;

    logic       CLK = 1'b0;
    logic       RSTN;
    logic       req_valid, req_ready, req_we;
    logic [6:0] req_addr;
    logic [7:0] req_wdata, req_wmask;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_rdata;
    logic       init_done;
    logic       sram_cen, sram_gwen;
    logic [7:0] sram_wen, sram_d;
    logic [6:0] sram_a;
    logic [7:0] q_r = 8'h00;

    always #5 CLK = ~CLK;

    sram128x8_ctrl dut (
        .CLK(CLK), .RSTN(RSTN),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .init_done(init_done),
        .sram_cen(sram_cen), .sram_gwen(sram_gwen), .sram_wen(sram_wen),
        .sram_a(sram_a), .sram_d(sram_d), .sram_q(q_r)
    );

    // Macro model: starts with random contents so the clear sweep matters
    logic [7:0] mem [128];
    logic       mem_seeded = 1'b0;
    always @(posedge CLK) begin
        if (!mem_seeded) begin
            for (int i = 0; i < 128; i++) mem[i] <= 8'($urandom);
            mem_seeded <= 1'b1;
        end else if (!sram_cen) begin
            if (sram_gwen) q_r <= mem[sram_a];
            else mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
        end
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard and reference memory
    logic [7:0] sc_q [$];
    logic [7:0] ref_mem [128];

    // Request accepted at the coming edge (set by stimulus, consumed by monitor)
    logic       acc_now = 1'b0;
    logic       acc_we;
    logic [6:0] acc_addr;
    logic [7:0] acc_wdata, acc_wmask;
    int         acc_cyc;

    logic       last_acc = 1'b0;
    logic       l_we;
    logic [6:0] l_addr;
    logic [7:0] l_wdata, l_wmask;
    logic [6:0] hold_a = 7'h00;
    logic       pin_chk_en = 1'b0;
    logic       hold_prev = 1'b0;
    logic [7:0] hold_data = 8'h00;

    always @(negedge CLK) begin
        #3;
        if (!RSTN) begin
            last_acc  = 1'b0;
            acc_now   = 1'b0;
            hold_prev = 1'b0;
        end else begin
            if (pin_chk_en) begin
                if (last_acc && l_we)
                    check("write pins", {sram_cen, sram_gwen, sram_wen, sram_a, sram_d},
                          {1'b0, 1'b0, ~l_wmask, l_addr, l_wdata});
                else if (last_acc)
                    check("read pins", {sram_cen, sram_gwen, sram_wen, sram_a},
                          {1'b0, 1'b1, 8'hFF, l_addr});
                else
                    check("idle pins", {sram_cen, sram_gwen, sram_wen, sram_a},
                          {1'b1, 1'b1, 8'hFF, hold_a});
            end
            if (last_acc) hold_a = l_addr;
            last_acc = acc_now;
            l_we = acc_we; l_addr = acc_addr; l_wdata = acc_wdata; l_wmask = acc_wmask;
            acc_now = 1'b0;

            if (hold_prev)
                check("rsp stable", {rsp_valid, rsp_rdata}, {1'b1, hold_data});
            if (rsp_valid && sc_q.size() == 0) begin
                check("rsp unexpected", {31'd0, rsp_valid}, 0);
            end else if (rsp_valid && rsp_ready) begin
                check("rsp data", rsp_rdata, sc_q.pop_front());
            end
            check("outstanding <= 4", sc_q.size() <= RSP_DEPTH, 1);
            hold_prev = rsp_valid && !rsp_ready;
            hold_data = rsp_rdata;
        end
    end

    task automatic book(input logic we, input logic [6:0] a, input logic [7:0] wd,
                        input logic [7:0] wm, input logic [7:0] exp, input bit use_exp);
        acc_now = 1'b1; acc_we = we; acc_addr = a; acc_wdata = wd; acc_wmask = wm;
        acc_cyc = cyc;
        if (we) ref_mem[a] = (ref_mem[a] & ~wm) | (wd & wm);
        else    sc_q.push_back(use_exp ? exp : ref_mem[a]);
    endtask

    task automatic send(input logic we, input logic [6:0] a, input logic [7:0] wd,
                        input logic [7:0] wm, input logic [7:0] exp, input bit use_exp);
        bit done   = 1'b0;
        int waited = 0;
        while (!done) begin
            @(negedge CLK);
            req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_wmask = wm;
            #1;
            if (req_ready) begin
                book(we, a, wd, wm, exp, use_exp);
                done = 1'b1;
            end else if (++waited > 200) begin
                check("req accept timeout", 1, 0);
                done = 1'b1;
            end
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while (sc_q.size() != 0 && t < 300) begin
            @(negedge CLK);
            req_valid = 1'b0;
            t++;
        end
        check("drain complete", sc_q.size(), 0);
        repeat (2) begin @(negedge CLK); req_valid = 1'b0; end
    endtask

    task automatic check_reset();
        check("rst req_ready", req_ready, 0);
        check("rst rsp_valid", rsp_valid, 0);
        check("rst rsp_rdata", rsp_rdata, 0);
        check("rst init_done", init_done, 0);
        check("rst sram_cen",  sram_cen,  1);
        check("rst sram_gwen", sram_gwen, 1);
        check("rst sram_wen",  sram_wen,  8'hFF);
        check("rst sram_a",    sram_a,    0);
        check("rst sram_d",    sram_d,    0);
    endtask

    // Called just after RSTN is released on a falling edge
    task automatic check_sweep(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge CLK); #2;
            check("sweep pins", {sram_cen, sram_gwen, sram_wen, sram_a, sram_d},
                  {1'b0, 1'b0, 8'h00, 7'(k), 8'h00});
            check("sweep init_done", init_done, k == 127);
            check("sweep req_ready", req_ready, k == 127);
        end
    endtask

    task automatic start_run_checks();
        for (int i = 0; i < 128; i++) ref_mem[i] = 8'h00;
        @(negedge CLK); #1;
        hold_a     = 7'h7F;
        pin_chk_en = 1'b1;
    endtask

    typedef struct {
        logic       we;
        logic [6:0] addr;
        logic [7:0] wdata;
        logic [7:0] wmask;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs [14];

    logic [6:0] bp_addr [8];

    initial begin
        int acc_n;
        int lat;
        vecs[0]  = '{1'b1, 7'h15, 8'hA5, 8'hFF, 8'h00};
        vecs[1]  = '{1'b0, 7'h15, 8'h00, 8'h00, 8'hA5};
        vecs[2]  = '{1'b1, 7'h20, 8'hFF, 8'hFF, 8'h00};
        vecs[3]  = '{1'b1, 7'h20, 8'h00, 8'h0F, 8'h00};
        vecs[4]  = '{1'b0, 7'h20, 8'h00, 8'h00, 8'hF0};
        vecs[5]  = '{1'b1, 7'h7F, 8'h3C, 8'hFF, 8'h00};
        vecs[6]  = '{1'b0, 7'h7F, 8'h00, 8'h00, 8'h3C};
        vecs[7]  = '{1'b1, 7'h30, 8'h55, 8'h00, 8'h00};
        vecs[8]  = '{1'b0, 7'h30, 8'h00, 8'h00, 8'h00};
        vecs[9]  = '{1'b0, 7'h00, 8'h00, 8'h00, 8'h00};
        vecs[10] = '{1'b1, 7'h01, 8'hC3, 8'hF0, 8'h00};
        vecs[11] = '{1'b0, 7'h01, 8'h00, 8'h00, 8'hC0};
        vecs[12] = '{1'b0, 7'h7F, 8'h00, 8'h00, 8'h3C};
        vecs[13] = '{1'b0, 7'h15, 8'h00, 8'h00, 8'hA5};
        bp_addr = '{7'h15, 7'h20, 7'h7F, 7'h01, 7'h30, 7'h00, 7'h40, 7'h41};

        RSTN = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; req_wmask = '0; rsp_ready = 1'b1;
        repeat (3) @(negedge CLK);
        #2; check_reset();

        // Clear sweep after reset release
        @(negedge CLK); RSTN = 1'b1;
        check_sweep(128);
        start_run_checks();

        // Write then read: response latency
        send(1'b1, 7'h15, 8'hA5, 8'hFF, 8'h00, 1'b0);
        send(1'b0, 7'h15, 8'h00, 8'h00, 8'hA5, 1'b1);
        lat = -1;
        for (int i = 0; i < 10 && lat < 0; i++) begin
            @(negedge CLK); req_valid = 1'b0; #2;
            if (rsp_valid) lat = cyc - acc_cyc;
        end
        check("read latency", lat, 3);
        wait_drain();

        // Table-driven back-to-back requests
        for (int i = 0; i < 14; i++)
            send(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wmask, vecs[i].exp, 1'b1);
        wait_drain();

        // Backpressure: 8 back-to-back reads with rsp_ready low
        acc_n = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge CLK);
            rsp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0;
            req_addr = bp_addr[acc_n]; req_wdata = '0; req_wmask = '0;
            #1;
            if (req_ready) begin
                book(1'b0, bp_addr[acc_n], 8'h00, 8'h00, 8'h00, 1'b0);
                acc_n++;
            end
        end
        check("backpressure accepted", acc_n, 4);
        check("backpressure req_ready", req_ready, 0);
        @(negedge CLK); rsp_ready = 1'b1;
        for (int i = acc_n; i < 8; i++)
            send(1'b0, bp_addr[i], 8'h00, 8'h00, 8'h00, 1'b0);
        wait_drain();

        // Reset with responses held in the FIFO
        @(negedge CLK); rsp_ready = 1'b0;
        send(1'b0, 7'h15, 8'h00, 8'h00, 8'h00, 1'b0);
        send(1'b0, 7'h20, 8'h00, 8'h00, 8'h00, 1'b0);
        repeat (4) begin @(negedge CLK); req_valid = 1'b0; end
        check("fifo holds data", rsp_valid, 1);
        RSTN = 1'b0; pin_chk_en = 1'b0; sc_q.delete();
        @(negedge CLK); #2; check_reset();
        rsp_ready = 1'b1;

        // Reset in the middle of the sweep restarts it at address 0
        @(negedge CLK); RSTN = 1'b1;
        check_sweep(50);
        RSTN = 1'b0;
        @(negedge CLK); #2; check_reset();
        @(negedge CLK); RSTN = 1'b1;
        check_sweep(128);
        start_run_checks();
        send(1'b0, 7'h15, 8'h00, 8'h00, 8'h00, 1'b1);
        send(1'b0, 7'h20, 8'h00, 8'h00, 8'h00, 1'b1);
        send(1'b1, 7'h7F, 8'h3C, 8'hFF, 8'h00, 1'b0);
        send(1'b0, 7'h7F, 8'h00, 8'h00, 8'h3C, 1'b1);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule : tb_sram128x8_ctrl
`default_nettype wire

// File: doc/sram128x8_ctrl.md
# sram128x8_ctrl

Host-side controller for the `gf180mcu_fd_ip_sram__sram128x8m8wm1` macro, which has 128 words of 8 bits.
- Converts a valid/ready request channel and a valid/ready read-response channel into the macro's active-low CEN/GWEN/WEN pin protocol.
- Clears the whole array after reset.
- Sits between on-chip bus logic and one SRAM instance; the macro's VDD/VSS stay at the top level.

## Interface
Parameters:
- `INIT_CLEAR`, 1: sweep-write `INIT_VALUE` to all 128 words after reset. When 0, go straight to run.
- `INIT_VALUE`, 8'h00: data written by the sweep.

Ports:
- `CLK` in 1: single clock, shared with the macro.
- `RSTN` in 1: reset, synchronous, active-low.
- `req_valid` in 1 / `req_ready` out 1: request handshake. Transfer occurs on a `CLK` edge with both high.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in 7: word address.
- `req_wdata` in 8: write data.
- `req_wmask` in 8: active-high bit-write enables.
- `rsp_valid` out 1 / `rsp_ready` in 1: read-response handshake.
- `rsp_rdata` out 8: read data.
- `init_done` out 1: high once the sweep completes and the block accepts requests.
- `sram_cen` out 1, `sram_gwen` out 1, `sram_wen` out 8, `sram_a` out 7, `sram_d` out 8: registered drives to the macro's CEN, GWEN, WEN, A and D.
- `sram_q` in 8: from macro Q.

## Operation
- **FSM** (state held in registers):
  - `RSTN` low: state `S_INIT` if `INIT_CLEAR`=1, else `S_RUN`.
  - `S_INIT`: one write per cycle to address `init_cnt` with `sram_cen`=0, `sram_gwen`=0, `sram_wen`=8'h00, `sram_d`=`INIT_VALUE`. `init_cnt` runs 0→127.
  - After address 127 is driven, go to `S_RUN`. `init_done` rises the same edge, so the sweep takes exactly 128 cycles.
  - `S_RUN` is terminal until reset.
  - `req_ready`=0 in `S_INIT`.
- **Pipeline** (one in-order pipe):
  - Stage A: pin registers, loaded on an accepted request.
  - Stage B: macro access edge.
  - Capture: `sram_q` is written into the response FIFO at the edge after stage B.
- **Write:** `sram_cen`=0, `sram_gwen`=0, `sram_wen`=~`req_wmask`, `sram_d`=`req_wdata`. No response is produced. `req_wmask`=0 is still issued and leaves the word unchanged.
- **Read:** `sram_cen`=0, `sram_gwen`=1, `sram_wen`=8'hFF. One response per read, in request order.
- **Idle cycle** (no accepted request): `sram_cen`=1, `sram_gwen`=1, `sram_wen`=8'hFF. `sram_a` and `sram_d` hold.
- **Response FIFO:** 4 entries.
- **Credit rule:**
  - In `S_RUN`, `req_ready` = (`fifo_count` + reads in stages A/B) < 4.
  - The rule is applied to writes too, for simplicity.
  - There is no combinational path from `rsp_ready` to `req_ready`.
- **FIFO boundaries:**
  - Empty → `rsp_valid`=0.
  - Capture and pop in the same cycle leave the count unchanged.
  - By the credit rule, capture into a full FIFO is impossible. The bench asserts this.
- **Ordering:** a read accepted after a write to the same address returns the new data, because the macro write precedes the read by ≥1 edge.
- **Reset mid-operation:**
  - FIFO flushed, in-flight reads dropped, pins idled.
  - With `INIT_CLEAR`=1 the sweep restarts at address 0.

## Timing
- **Reset values:** `req_ready`=0, `rsp_valid`=0, `rsp_rdata`=0, `init_done`=0, `sram_cen`=1, `sram_gwen`=1, `sram_wen`=8'hFF, `sram_a`=0, `sram_d`=0.
- **Read latency:** request accepted at edge N → pins valid after N → macro samples at N+1 → FIFO written at N+2 → `rsp_valid`=1 in the cycle after N+2.
- **Throughput:** 1 request/cycle is sustained while `rsp_ready`=1.
- **Backpressure:** with `rsp_ready`=0, at most 4 reads are accepted, then `req_ready`=0.
- **Stability:** `rsp_rdata` is stable while `rsp_valid`=1 and `rsp_ready`=0.

## Structure
- Package `sram128x8_ctrl_pkg`:
  - constants `AW`=7, `DW`=8, `DEPTH`=128, `RSP_DEPTH`=4;
  - state enum {`S_INIT`, `S_RUN`};
  - request struct {we, addr, wdata, wmask}.
- Sub-module `sram128x8_ctrl_rspfifo`: 4-entry synchronous FIFO with `count` output and the same reset.
- Top level holds the FSM, `init_cnt`, stage A/B valid/read flags and the pin registers.

## Test plan
- **Init sweep:** reset release with `INIT_CLEAR`=1 → 128 consecutive writes to addresses 0..127 with `sram_wen`=8'h00 and `sram_d`=8'h00; `init_done` high at cycle 128; `req_ready`=0 until then.
- **Write then read:** write addr 7'h15 data 8'hA5 mask 8'hFF, then read 7'h15 → `rsp_rdata`=8'hA5, `rsp_valid` rising 3 cycles after read acceptance.
- **Masked write:** word holds 8'hFF; write data 8'h00 with mask 8'h0F → `sram_wen`=8'hF0; read returns 8'hF0.
- **Back-to-back reads with backpressure:** 8 back-to-back reads with `rsp_ready`=0 → exactly 4 accepted, then `req_ready`=0; releasing `rsp_ready` drains the data in order; FIFO overflow never occurs.
- **Reset mid-sweep:** `RSTN` low at sweep cycle 50 → pins idle next edge; sweep restarts at address 0; `rsp_valid`=0.
- **Read-after-write hazard:** write 7'h7F data 8'h3C immediately followed by a read of 7'h7F on consecutive cycles → read returns 8'h3C.
